// File: rtl/alu_issue_stage_if.sv
// Decode-to-issue and issue-to-execute handshake bundles.
// master drives the payload and valid; slave returns ready.
interface alu_issue_id_if #(
  parameter int BITS = 32
);
  logic            valid;
  logic            ready;
  logic [1:0]      alu_ctrl;
  logic            is_signed;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [BITS-1:0] rs1_data;
  logic [BITS-1:0] rs2_data;
  logic [BITS-1:0] imm;
  logic            use_imm;
  logic [4:0]      rd;
  logic            rd_we;
  logic            is_load;

  modport master (
    output valid, alu_ctrl, is_signed,
    output rs1, rs2, rs1_data, rs2_data,
    output imm, use_imm, rd, rd_we, is_load,
    input  ready
  );

  modport slave (
    input  valid, alu_ctrl, is_signed,
    input  rs1, rs2, rs1_data, rs2_data,
    input  imm, use_imm, rd, rd_we, is_load,
    output ready
  );
endinterface

interface alu_issue_ex_if #(
  parameter int BITS = 32
);
  logic            valid;
  logic            ready;
  logic [1:0]      alu_control;
  logic            is_signed;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic [4:0]      rd;
  logic            rd_we;
  logic            is_load;

  modport master (
    output valid, alu_control, is_signed,
    output a, b, rd, rd_we, is_load,
    input  ready
  );

  modport slave (
    input  valid, alu_control, is_signed,
    input  a, b, rd, rd_we, is_load,
    output ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX boundary: operand forwarding, load-use bubbles, hold refresh.
// Define ALU_ISSUE_FWD_EN to enable MEM/WB forwarding.
module alu_issue_stage #(
  parameter int BITS        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_issue_id_if.slave          id,
  input  logic [4:0]             mem_rd,
  input  logic                   mem_rd_we,
  input  logic [BITS-1:0]        mem_result,
  input  logic [4:0]             wb_rd,
  input  logic                   wb_rd_we,
  input  logic [BITS-1:0]        wb_result,
  input  logic                   flush,
  alu_issue_ex_if.master         ex,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] STALL_ONE =
    {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic            valid_q;
  logic [1:0]      ctrl_q;
  logic            signed_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [BITS-1:0] rs1_d_q;
  logic [BITS-1:0] rs2_d_q;
  logic [BITS-1:0] imm_q;
  logic            use_imm_q;
  logic [4:0]      rd_q;
  logic            rd_we_q;
  logic            load_q;

  logic [BITS-1:0] fwd1;
  logic [BITS-1:0] fwd2;
  logic            haz;
  logic            xfer;

  function automatic logic hit(
    input logic       we,
    input logic [4:0] dst,
    input logic [4:0] src
  );
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic raw(
    input logic       we,
    input logic [4:0] dst,
    input logic [4:0] s1,
    input logic [4:0] s2,
    input logic       imm_sel
  );
    return hit(we, dst, s1) || (!imm_sel && hit(we, dst, s2));
  endfunction

`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    fwd1 = rs1_d_q;
    if (hit(mem_rd_we, mem_rd, rs1_q))
      fwd1 = mem_result;
    else if (hit(wb_rd_we, wb_rd, rs1_q))
      fwd1 = wb_result;
  end

  always_comb begin
    fwd2 = rs2_d_q;
    if (hit(mem_rd_we, mem_rd, rs2_q))
      fwd2 = mem_result;
    else if (hit(wb_rd_we, wb_rd, rs2_q))
      fwd2 = wb_result;
  end

  // Only a load in EX cannot be forwarded in time.
  assign haz = valid_q && load_q &&
    raw(rd_we_q, rd_q, id.rs1, id.rs2, id.use_imm);
`else
  logic unused_fwd;

  assign fwd1 = rs1_d_q;
  assign fwd2 = rs2_d_q;
  assign unused_fwd =
    ^{mem_result, wb_result, rs1_q, rs2_q};

  // Regfile writes at the end of WB, so every producer stalls.
  assign haz =
    raw(valid_q && rd_we_q, rd_q,
        id.rs1, id.rs2, id.use_imm) ||
    raw(mem_rd_we, mem_rd,
        id.rs1, id.rs2, id.use_imm) ||
    raw(wb_rd_we, wb_rd,
        id.rs1, id.rs2, id.use_imm);
`endif

  assign id.ready = !haz && (!valid_q || ex.ready);
  assign xfer     = id.valid && id.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= 2'd0;
      signed_q  <= 1'b0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rs1_d_q   <= '0;
      rs2_d_q   <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      rd_q      <= 5'd0;
      rd_we_q   <= 1'b0;
      load_q    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (xfer) begin
        valid_q   <= 1'b1;
        ctrl_q    <= id.alu_ctrl;
        signed_q  <= id.is_signed;
        rs1_q     <= id.rs1;
        rs2_q     <= id.rs2;
        rs1_d_q   <= id.rs1_data;
        rs2_d_q   <= id.rs2_data;
        imm_q     <= id.imm;
        use_imm_q <= id.use_imm;
        rd_q      <= id.rd;
        rd_we_q   <= id.rd_we;
        load_q    <= id.is_load;
      end else if (ex.ready || !valid_q) begin
        valid_q <= 1'b0;
`ifdef ALU_ISSUE_FWD_EN
      end else begin
        // Capture producers that may retire before EX consumes us.
        rs1_d_q <= fwd1;
        rs2_d_q <= fwd2;
`endif
      end
      if (id.valid && haz && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_ONE;
    end
  end

  assign ex.valid       = valid_q;
  assign ex.alu_control = ctrl_q;
  assign ex.is_signed   = signed_q;
  assign ex.a           = fwd1;
  assign ex.b           = use_imm_q ? imm_q : fwd2;
  assign ex.rd          = rd_q;
  assign ex.rd_we       = rd_we_q;
  assign ex.is_load     = load_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural model plus directed vectors.
// Builds for either setting of ALU_ISSUE_FWD_EN.
module tb_alu_issue_stage;
  localparam int BITS = 32;
  localparam int SW   = 16;
`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int unsigned SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]      mem_rd = 5'd0;
  logic            mem_rd_we = 1'b0;
  logic [BITS-1:0] mem_result = '0;
  logic [4:0]      wb_rd = 5'd0;
  logic            wb_rd_we = 1'b0;
  logic [BITS-1:0] wb_result = '0;
  logic            flush = 1'b0;
  logic [SW-1:0]   stall_cnt;

  alu_issue_id_if #(.BITS(BITS)) idb ();
  alu_issue_ex_if #(.BITS(BITS)) exb ();

  alu_issue_stage #(.BITS(BITS), .STALL_CNT_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id         (idb),
    .mem_rd     (mem_rd),
    .mem_rd_we  (mem_rd_we),
    .mem_result (mem_result),
    .wb_rd      (wb_rd),
    .wb_rd_we   (wb_rd_we),
    .wb_result  (wb_result),
    .flush      (flush),
    .ex         (exb),
    .stall_cnt  (stall_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h",
               name, $time, act, exp);
    end
  endtask

  // Model: what the held instruction is and which operand values it saw.
  bit          m_valid;
  logic [1:0]  m_ctrl;
  bit          m_sgn;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_v1, m_v2, m_imm;
  bit          m_use_imm, m_rd_we, m_load;
  int unsigned m_stalls;
  logic [31:0] e_a, e_b, n_v1, n_v2;
  bit          e_rdy, e_haz;

  function automatic logic [31:0] see(input logic [4:0] src,
                                      input logic [31:0] held);
    if (!FWD || src == 5'd0) return held;
    if (mem_rd_we && mem_rd == src) return mem_result;
    if (wb_rd_we && wb_rd == src) return wb_result;
    return held;
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return r != 5'd0 &&
      (idb.rs1 == r || (!idb.use_imm && idb.rs2 == r));
  endfunction

  function automatic bit hazard();
    if (FWD) return m_valid && m_load && m_rd_we && reads(m_rd);
    return (m_valid && m_rd_we && reads(m_rd)) ||
           (mem_rd_we && reads(mem_rd)) ||
           (wb_rd_we && reads(wb_rd));
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 0; m_ctrl = 0; m_sgn = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_v1 = 0; m_v2 = 0; m_imm = 0;
      m_use_imm = 0; m_rd_we = 0; m_load = 0;
      m_stalls = 0;
    end
    e_haz = hazard();
    e_rdy = !e_haz && (!m_valid || exb.ready);
    n_v1  = see(m_rs1, m_v1);
    n_v2  = see(m_rs2, m_v2);
    e_a   = n_v1;
    e_b   = m_use_imm ? m_imm : n_v2;
    check("ex_valid", exb.valid, m_valid);
    check("id_ready", idb.ready, e_rdy);
    check("alu_control", exb.alu_control, m_ctrl);
    check("is_signed", exb.is_signed, m_sgn);
    check("a", exb.a, e_a);
    check("b", exb.b, e_b);
    check("ex_rd", exb.rd, m_rd);
    check("ex_rd_we", exb.rd_we, m_rd_we);
    check("ex_is_load", exb.is_load, m_load);
    check("stall_cnt", stall_cnt, m_stalls);
    if (rst_n) begin
      if (idb.valid && e_haz && m_stalls < SMAX) m_stalls++;
      if (flush) begin
        m_valid = 0;
      end else if (idb.valid && e_rdy) begin
        m_valid = 1; m_ctrl = idb.alu_ctrl; m_sgn = idb.is_signed;
        m_rs1 = idb.rs1; m_rs2 = idb.rs2; m_rd = idb.rd;
        m_v1 = idb.rs1_data; m_v2 = idb.rs2_data; m_imm = idb.imm;
        m_use_imm = idb.use_imm; m_rd_we = idb.rd_we;
        m_load = idb.is_load;
      end else if (exb.ready || !m_valid) begin
        m_valid = 0;
      end else begin
        m_v1 = n_v1;
        m_v2 = n_v2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] ctrl, input logic sgn,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic use_imm,
                       input logic [4:0] rd, input logic load);
    idb.valid = 1; idb.alu_ctrl = ctrl; idb.is_signed = sgn;
    idb.rs1 = rs1; idb.rs2 = rs2;
    idb.rs1_data = d1; idb.rs2_data = d2;
    idb.imm = imm; idb.use_imm = use_imm;
    idb.rd = rd; idb.rd_we = 1; idb.is_load = load;
  endtask

  initial begin
    idb.valid = 0; idb.alu_ctrl = 0; idb.is_signed = 0;
    idb.rs1 = 0; idb.rs2 = 0; idb.rs1_data = 0; idb.rs2_data = 0;
    idb.imm = 0; idb.use_imm = 0; idb.rd = 0; idb.rd_we = 0;
    idb.is_load = 0; exb.ready = 1;
    repeat (3) step();
    @(negedge clk);
    check("rst ex_valid", exb.valid, 0);
    check("rst a", exb.a, 0);
    check("rst b", exb.b, 0);
    check("rst ready", idb.ready, 1);
    step(); rst_n = 1;

    // MEM beats WB on rs1; WB supplies rs2.
    issue(2'd2, 1, 5, 6, 32'h100, 32'h200, 0, 0, 8, 0);
    step();
    idb.valid = 0; exb.ready = 0;
    mem_rd = 5; mem_rd_we = 1; mem_result = 32'h11;
    wb_rd = 5; wb_rd_we = 1; wb_result = 32'h22;
    @(negedge clk);
    check("add ctrl", exb.alu_control, 2);
    check("add a mem", exb.a, FWD ? 32'h11 : 32'h100);
    step();
    mem_rd_we = 0; wb_rd = 6; wb_result = 32'h33;
    @(negedge clk);
    check("add b wb", exb.b, FWD ? 32'h33 : 32'h200);
    check("add a kept", exb.a, FWD ? 32'h11 : 32'h100);
    step();
    exb.ready = 1; wb_rd_we = 0;
    issue(2'd0, 0, 1, 2, 0, 0, 4, 1, 7, 1);

    // Load-use on x7.
    step();
    issue(2'd1, 0, 7, 3, 32'h1, 32'h5, 0, 0, 9, 0);
    @(negedge clk);
    check("lu stall", idb.ready, 0);
    step();
    mem_rd = 7; mem_rd_we = 1; mem_result = 0;
    @(negedge clk);
    check("lu bubble", exb.valid, 0);
    check("lu ready", idb.ready, FWD);
    step();
    mem_rd_we = 0; wb_rd = 7; wb_rd_we = 1; wb_result = 32'hDEAD;
    if (FWD) idb.valid = 0;
    @(negedge clk);
    if (FWD) begin
      check("lu a", exb.a, 32'hDEAD);
      check("lu stalls", stall_cnt, 1);
    end else begin
      check("lu stall3", idb.ready, 0);
      step();
      wb_rd_we = 0; idb.rs1_data = 32'hDEAD;
      @(negedge clk);
      check("lu ready4", idb.ready, 1);
      step();
      idb.valid = 0;
      @(negedge clk);
      check("lu a", exb.a, 32'hDEAD);
      check("lu stalls", stall_cnt, 3);
    end
    step();
    idb.valid = 0; wb_rd_we = 0;

    // Hold with a one-cycle MEM producer.
    step();
    issue(2'd0, 0, 9, 10, 32'h5, 32'h6, 0, 0, 11, 0);
    step();
    idb.valid = 0; exb.ready = 0;
    mem_rd = 9; mem_rd_we = 1; mem_result = 32'h44;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold a", exb.a, FWD ? 32'h44 : 32'h5);
      step();
      mem_rd_we = 0;
    end

    // x0 never forwards; immediate drives B.
    exb.ready = 1;
    mem_rd = 0; mem_rd_we = 1; mem_result = 32'h99;
    issue(2'd3, 1, 0, 11, 0, 32'h77, 32'h800, 1, 12, 0);
    @(negedge clk);
    check("imm ready", idb.ready, 1);
    step();
    idb.valid = 0; exb.ready = 0;
    @(negedge clk);
    check("x0 a", exb.a, 0);
    check("imm b", exb.b, 32'h800);

    // Flush while holding, then flush while idle.
    step();
    mem_rd_we = 0; flush = 1;
    issue(2'd1, 0, 1, 2, 0, 0, 0, 0, 13, 0);
    step();
    flush = 0; idb.valid = 0;
    @(negedge clk);
    check("flush valid", exb.valid, 0);
    check("flush rd", exb.rd, 12);
    step();
    exb.ready = 1; flush = 1;
    issue(2'd1, 0, 3, 4, 0, 0, 0, 0, 14, 0);
    @(negedge clk);
    check("flush2 ready", idb.ready, 1);
    step();
    flush = 0; idb.valid = 0;
    @(negedge clk);
    check("flush2 rd", exb.rd, 12);

    // Asynchronous reset during a hold.
    step();
    issue(2'd2, 1, 20, 21, 32'hABC, 0, 0, 0, 15, 0);
    step();
    idb.valid = 0; exb.ready = 0;
    @(negedge clk);
    check("pre-rst valid", exb.valid, 1);
    step();
    rst_n = 0;
    #1;
    check("async valid", exb.valid, 0);
    check("async stalls", stall_cnt, 0);
    step(); step();
    rst_n = 1; exb.ready = 1;

    // Mixed stream, checked by the model every cycle.
    for (int i = 0; i < 80; i++) begin
      step();
      idb.valid = (i % 3) != 0;
      idb.alu_ctrl = 2'(i % 4); idb.is_signed = i[0];
      idb.rs1 = 5'(i % 5); idb.rs2 = 5'((i * 3) % 5);
      idb.rs1_data = 32'h1000 + i; idb.rs2_data = 32'h2000 + i;
      idb.imm = 32'h300 + i; idb.use_imm = (i % 4) == 3;
      idb.rd = 5'((i + 1) % 5); idb.rd_we = (i % 6) != 5;
      idb.is_load = (i % 4) == 1;
      mem_rd = 5'((i + 2) % 5); mem_rd_we = (i % 3) != 2;
      mem_result = 32'h4000 + i;
      wb_rd = 5'((i + 4) % 5); wb_rd_we = i[0];
      wb_result = 32'h5000 + i;
      exb.ready = (i % 5) != 2;
      flush = (i % 13) == 12;
    end
    step();
    idb.valid = 0; flush = 0; exb.ready = 1;
    mem_rd_we = 0; wb_rd_we = 0;
    repeat (3) step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
